leaf_router: RTL and testbench

- First-hop switch directly downstream of the per-GPU network interfaces. Serves the 4 GPUs of one group plus one uplink toward the group-level fabric.
- Accepts 16-bit single-flit packets whose bits [15:10] hold the routing header: group in bits [5:2], leaf in bits [1:0].
- Buffers each input, decodes the header and round-robin arbitrates each output.
- Delivers each flit to the addressed local NI, or forwards it out the uplink.

---
 rtl/noc_pkg.sv | 31 +++
 rtl/flit_fifo.sv | 65 ++++++
 rtl/leaf_router.sv | 195 +++++++++++++++++++
 tb/tb_leaf_router.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Brief    : Shared flit geometry, header field slices, port indices and
//            route codes for the leaf-level switch.
// Revision : 1.0
// ============================================================================
package noc_pkg;

    localparam int DATA_W   = 16;
    localparam int HEADER_W = 6;

    localparam int HDR_MSB  = 15;
    localparam int GRP_MSB  = 15;
    localparam int GRP_LSB  = 12;
    localparam int LEAF_MSB = 11;
    localparam int LEAF_LSB = 10;

    localparam int LEAF0   = 0;
    localparam int LEAF1   = 1;
    localparam int LEAF2   = 2;
    localparam int LEAF3   = 3;
    localparam int PORT_UP = 4;
    localparam int NUM_IN  = 5;

    localparam logic [1:0] ROUTE_LOC  = 2'd0;
    localparam logic [1:0] ROUTE_UP   = 2'd1;
    localparam logic [1:0] ROUTE_DROP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/flit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : flit_fifo
// Brief    : Synchronous single-clock flit FIFO with first-word-fall-through
//            head. A push while full is refused even if a pop coincides.
// Revision : 1.0
// ============================================================================
module flit_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int c_addr_w = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign full      = (r_count == (c_addr_w+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage is not reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/leaf_router.sv
`default_nettype none
// ============================================================================
// Module   : leaf_router
// Brief    : First-hop switch for four local GPUs plus one group uplink.
//            Per-input FIFOs, head decode, per-output round-robin arbitration.
// Revision : 1.0
// ============================================================================
module leaf_router #(
    parameter logic [3:0] GROUP_ID   = 4'd3,
    parameter int         DATA_W     = 16,
    parameter int         HEADER_W   = 6,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DATA_W-1:0] loc_data_in,
    input  logic [3:0]          loc_valid_in,
    output logic [3:0]          loc_ready_out,
    output logic [4*DATA_W-1:0] loc_data_out,
    output logic [3:0]          loc_valid_out,
    input  logic [DATA_W-1:0]   up_data_in,
    input  logic                up_valid_in,
    output logic                up_ready_out,
    output logic [DATA_W-1:0]   up_data_out,
    output logic                up_valid_out,
    input  logic                up_ready_in,
    output logic [7:0]          drop_count
);

    import noc_pkg::*;

    logic [DATA_W-1:0] w_in_data [NUM_IN];
    logic [NUM_IN-1:0] w_in_valid;
    logic [NUM_IN-1:0] w_ready;
    logic [NUM_IN-1:0] w_push;
    logic [NUM_IN-1:0] w_pop;
    logic [NUM_IN-1:0] w_full;
    logic [NUM_IN-1:0] w_empty;
    logic [DATA_W-1:0] w_head [NUM_IN];
    logic [1:0]        w_route [NUM_IN];
    logic [2:0]        w_tgt [NUM_IN];
    logic [NUM_IN-1:0] w_req [NUM_IN];
    logic [NUM_IN-1:0] w_gnt_ok;
    logic [2:0]        w_win [NUM_IN];
    logic [2:0]        w_ndrop;
    logic [8:0]        w_drop_sum;
    logic              w_up_free;

    logic [2:0]        r_ptr [NUM_IN];
    logic [DATA_W-1:0] r_loc_data [4];
    logic [3:0]        r_loc_valid;
    logic [DATA_W-1:0] r_up_data;
    logic              r_up_valid;
    logic [7:0]        r_drop_count;

    assign w_in_valid = {up_valid_in, loc_valid_in};
    assign w_up_free  = !r_up_valid || up_ready_in;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
            if (gi < PORT_UP) begin : g_leaf_src
                assign w_in_data[gi] = loc_data_in[gi*DATA_W +: DATA_W];
            end else begin : g_up_src
                assign w_in_data[gi] = up_data_in;
            end

            // Ready is purely registered state; held low while in reset.
            assign w_ready[gi] = reset && !w_full[gi];
            assign w_push[gi]  = w_in_valid[gi] && w_ready[gi];

            flit_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (w_push[gi]),
                .pop   (w_pop[gi]),
                .din   (w_in_data[gi]),
                .full  (w_full[gi]),
                .empty (w_empty[gi]),
                .head  (w_head[gi])
            );
        end

        for (genvar go = 0; go < 4; go++) begin : g_loc_out
            assign loc_data_out[go*DATA_W +: DATA_W] = r_loc_data[go];
        end
    endgenerate

    assign loc_ready_out = w_ready[3:0];
    assign up_ready_out  = w_ready[PORT_UP];
    assign loc_valid_out = r_loc_valid;
    assign up_data_out   = r_up_data;
    assign up_valid_out  = r_up_valid;
    assign drop_count    = r_drop_count;

    // Head decode: uplink-sourced flits for a foreign group are discarded.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            w_route[i] = ROUTE_DROP;
            w_tgt[i]   = 3'(PORT_UP);
            if (w_head[i][HDR_MSB -: HEADER_W] == '0) begin
                w_route[i] = ROUTE_DROP;
            end else if (w_head[i][GRP_MSB:GRP_LSB] == GROUP_ID) begin
                w_route[i] = ROUTE_LOC;
                w_tgt[i]   = {1'b0, w_head[i][LEAF_MSB:LEAF_LSB]};
            end else if (i != PORT_UP) begin
                w_route[i] = ROUTE_UP;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_IN; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                w_req[o][i] = !w_empty[i] && (w_route[i] != ROUTE_DROP) &&
                              (w_tgt[i] == 3'(o));
            end
        end
    end

    always_comb begin
        logic       found;
        logic [3:0] sum;
        logic [2:0] idx;
        for (int o = 0; o < NUM_IN; o++) begin
            found    = 1'b0;
            w_win[o] = '0;
            for (int k = 0; k < NUM_IN; k++) begin
                sum = {1'b0, r_ptr[o]} + 4'(k);
                idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
                if (!found && w_req[o][idx]) begin
                    found    = 1'b1;
                    w_win[o] = idx;
                end
            end
            w_gnt_ok[o] = found && ((o != PORT_UP) || w_up_free);
        end
    end

    always_comb begin
        w_pop   = '0;
        w_ndrop = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!w_empty[i] && (w_route[i] == ROUTE_DROP)) begin
                w_pop[i] = 1'b1;
                w_ndrop  = w_ndrop + 3'd1;
            end
        end
        for (int o = 0; o < NUM_IN; o++) begin
            if (w_gnt_ok[o]) begin
                w_pop[w_win[o]] = 1'b1;
            end
        end
    end

    assign w_drop_sum = {1'b0, r_drop_count} + {6'd0, w_ndrop};

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int o = 0; o < NUM_IN; o++) begin
                r_ptr[o] <= '0;
            end
            for (int o = 0; o < 4; o++) begin
                r_loc_data[o] <= '0;
            end
            r_loc_valid  <= '0;
            r_up_data    <= '0;
            r_up_valid   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            for (int o = 0; o < NUM_IN; o++) begin
                if (w_gnt_ok[o]) begin
                    r_ptr[o] <= (w_win[o] == 3'(PORT_UP)) ? 3'd0 : w_win[o] + 3'd1;
                end
            end
            for (int o = 0; o < 4; o++) begin
                r_loc_valid[o] <= w_gnt_ok[o];
                if (w_gnt_ok[o]) begin
                    r_loc_data[o] <= w_head[w_win[o]];
                end
            end
            if (w_gnt_ok[PORT_UP]) begin
                r_up_valid <= 1'b1;
                r_up_data  <= w_head[w_win[PORT_UP]];
            end else if (up_ready_in) begin
                r_up_valid <= 1'b0;
            end
            r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_leaf_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaf_router
// Brief    : Directed self-checking bench for leaf_router (GROUP_ID = 3).
// Revision : 1.0
// ============================================================================
module tb_leaf_router;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] loc_data_in;
    logic [3:0]  loc_valid_in;
    logic [3:0]  loc_ready_out;
    logic [63:0] loc_data_out;
    logic [3:0]  loc_valid_out;
    logic [15:0] up_data_in;
    logic        up_valid_in;
    logic        up_ready_out;
    logic [15:0] up_data_out;
    logic        up_valid_out;
    logic        up_ready_in;
    logic [7:0]  drop_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    leaf_router #(
        .GROUP_ID   (4'd3),
        .DATA_W     (16),
        .HEADER_W   (6),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .loc_data_in   (loc_data_in),
        .loc_valid_in  (loc_valid_in),
        .loc_ready_out (loc_ready_out),
        .loc_data_out  (loc_data_out),
        .loc_valid_out (loc_valid_out),
        .up_data_in    (up_data_in),
        .up_valid_in   (up_valid_in),
        .up_ready_out  (up_ready_out),
        .up_data_out   (up_data_out),
        .up_valid_out  (up_valid_out),
        .up_ready_in   (up_ready_in),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_seq [8];
        int          got;
        int          seen;
        logic        accept;

        reset        = 1'b0;
        loc_data_in  = '0;
        loc_valid_in = '0;
        up_data_in   = '0;
        up_valid_in  = 1'b0;
        up_ready_in  = 1'b1;
        repeat (3) tick();

        check("rst_loc_valid", 64'(loc_valid_out), 64'h0);
        check("rst_loc_data",  loc_data_out,       64'h0);
        check("rst_up_valid",  64'(up_valid_out),  64'h0);
        check("rst_up_data",   64'(up_data_out),   64'h0);
        check("rst_drops",     64'(drop_count),    64'h0);

        reset = 1'b1;
        tick();
        check("rel_loc_ready", 64'(loc_ready_out), 64'hF);
        check("rel_up_ready",  64'(up_ready_out),  64'h1);

        // Leaf 1 to itself (group 3, leaf 1).
        loc_data_in[31:16] = 16'h3455;
        loc_valid_in[1]    = 1'b1;
        tick();
        loc_valid_in[1] = 1'b0;
        check("lat_not_early", 64'(loc_valid_out[1]), 64'h0);
        tick();
        check("lat_valid",     64'(loc_valid_out[1]), 64'h1);
        check("lat_data",      64'(loc_data_out[31:16]), 64'h3455);
        check("lat_drops",     64'(drop_count), 64'h0);
        tick();
        check("pulse_once",    64'(loc_valid_out[1]), 64'h0);
        check("data_hold",     64'(loc_data_out[31:16]), 64'h3455);

        // Leaf 0 to group 5 with a stalled uplink.
        up_ready_in       = 1'b0;
        loc_data_in[15:0] = 16'h5003;
        loc_valid_in[0]   = 1'b1;
        tick();
        loc_valid_in[0] = 1'b0;
        tick();
        for (int c = 0; c < 6; c++) begin
            check("stall_valid", 64'(up_valid_out), 64'h1);
            check("stall_data",  64'(up_data_out),  64'h5003);
            if (c < 5) tick();
        end
        up_ready_in = 1'b1;
        tick();
        check("stall_release", 64'(up_valid_out), 64'h0);

        // Four sources to leaf 2, two rounds: order 0,2,3,4,0,2,3,4.
        exp_seq = '{16'h3800, 16'h3802, 16'h3803, 16'h3804,
                    16'h3810, 16'h3812, 16'h3813, 16'h3814};
        loc_data_in  = {16'h3803, 16'h3802, 16'h0000, 16'h3800};
        loc_valid_in = 4'b1101;
        up_data_in   = 16'h3804;
        up_valid_in  = 1'b1;
        tick();
        loc_data_in = {16'h3813, 16'h3812, 16'h0000, 16'h3810};
        up_data_in  = 16'h3814;
        tick();
        loc_valid_in = '0;
        up_valid_in  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check("rr_valid", 64'(loc_valid_out[2]), 64'h1);
            check("rr_data",  64'(loc_data_out[47:32]), 64'(exp_seq[c]));
            tick();
        end
        check("rr_drained", 64'(loc_valid_out[2]), 64'h0);

        // Uplink U-turn and null header are both discarded in one cycle.
        up_data_in         = 16'h1400;
        up_valid_in        = 1'b1;
        loc_data_in[63:48] = 16'h03FF;
        loc_valid_in[3]    = 1'b1;
        tick();
        up_valid_in  = 1'b0;
        loc_valid_in = '0;
        tick();
        check("drop_count",   64'(drop_count),    64'h2);
        check("drop_no_loc",  64'(loc_valid_out), 64'h0);
        check("drop_no_up",   64'(up_valid_out),  64'h0);
        tick();
        check("drop_no_loc2", 64'(loc_valid_out), 64'h0);

        // Backpressure: 4 buffered plus 1 registered, then drain in order.
        up_ready_in     = 1'b0;
        loc_valid_in[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            loc_data_in[15:0] = 16'h5000 + 16'(k);
            check("bp_ready_high", 64'(loc_ready_out[0]), 64'h1);
            tick();
        end
        loc_data_in[15:0] = 16'h5005;
        check("bp_ready_low", 64'(loc_ready_out[0]), 64'h0);
        check("bp_head_reg",  64'(up_data_out), 64'h5000);
        up_ready_in = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 6; c++) begin
            if (up_valid_out && up_ready_in) begin
                check("bp_order", 64'(up_data_out), 64'(16'h5000 + 16'(got)));
                got++;
            end
            accept = loc_valid_in[0] && loc_ready_out[0];
            tick();
            if (accept) loc_valid_in[0] = 1'b0;
        end
        check("bp_drained_all", 64'(got), 64'd6);
        check("bp_idle",        64'(up_valid_out), 64'h0);

        // Reset while flits are buffered.
        up_ready_in     = 1'b0;
        loc_valid_in[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            loc_data_in[15:0] = 16'h5010 + 16'(k);
            tick();
        end
        loc_valid_in[0] = 1'b0;
        tick();
        check("pre_rst_up_valid", 64'(up_valid_out), 64'h1);
        reset = 1'b0;
        tick();
        check("mid_rst_up_valid",  64'(up_valid_out),  64'h0);
        check("mid_rst_up_data",   64'(up_data_out),   64'h0);
        check("mid_rst_loc_valid", 64'(loc_valid_out), 64'h0);
        check("mid_rst_loc_data",  loc_data_out,       64'h0);
        check("mid_rst_drops",     64'(drop_count),    64'h0);
        reset       = 1'b1;
        up_ready_in = 1'b1;
        tick();
        check("post_rst_loc_ready", 64'(loc_ready_out), 64'hF);
        check("post_rst_up_ready",  64'(up_ready_out),  64'h1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (up_valid_out || (loc_valid_out != 4'h0)) seen++;
            tick();
        end
        check("post_rst_no_stale", 64'(seen), 64'd0);
        check("post_rst_drops",    64'(drop_count), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
